// File: rtl/aplic_reg_initiator.sv
// Register-interface initiator: buffers read/write commands in a small FIFO and
// issues them one at a time to the APLIC config port, returning data/error/timeout.
module aplic_reg_initiator #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        i_clk,
  input  logic        ni_rst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [31:0] i_cmd_addr,
  input  logic        i_cmd_write,
  input  logic [31:0] i_cmd_wdata,
  input  logic [3:0]  i_cmd_wstrb,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_error,
  output logic        o_rsp_timeout,
  output logic        o_busy,
  output logic [31:0] reg_intf_req_a32_d32_addr,
  output logic        reg_intf_req_a32_d32_write,
  output logic [31:0] reg_intf_req_a32_d32_wdata,
  output logic [3:0]  reg_intf_req_a32_d32_wstrb,
  output logic        reg_intf_req_a32_d32_valid,
  input  logic [31:0] reg_intf_resp_d32_rdata,
  input  logic        reg_intf_resp_d32_error,
  input  logic        reg_intf_resp_d32_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TMO_LAST   = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam bit            TMO_EN     = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, RSP} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_t;

  cmd_t          mem [FIFO_DEPTH];
  cmd_t          head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;
  state_t        state;
  logic [TW-1:0] tmo_cnt;

  // Ready comes only from the registered count, so a full FIFO refuses even while popping.
  assign o_cmd_ready = (count != FULL_COUNT);
  assign push        = i_cmd_valid && o_cmd_ready;
  assign pop         = (state == IDLE) && (count != '0);
  assign head        = mem[rd_ptr];
  assign o_busy      = (count != '0) || (state != IDLE);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= {i_cmd_addr, i_cmd_write, i_cmd_wdata, i_cmd_wstrb};
  end

  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
    end
  end

  // Strictly one transaction outstanding: a pending response blocks the next pop.
  always_ff @(posedge i_clk) begin
    if (!ni_rst) begin
      state                      <= IDLE;
      tmo_cnt                    <= '0;
      reg_intf_req_a32_d32_addr  <= '0;
      reg_intf_req_a32_d32_write <= 1'b0;
      reg_intf_req_a32_d32_wdata <= '0;
      reg_intf_req_a32_d32_wstrb <= '0;
      reg_intf_req_a32_d32_valid <= 1'b0;
      o_rsp_valid                <= 1'b0;
      o_rsp_rdata                <= '0;
      o_rsp_error                <= 1'b0;
      o_rsp_timeout              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            reg_intf_req_a32_d32_addr  <= head.addr;
            reg_intf_req_a32_d32_write <= head.write;
            reg_intf_req_a32_d32_wdata <= head.write ? head.wdata : '0;
            reg_intf_req_a32_d32_wstrb <= head.write ? head.wstrb : '0;
            reg_intf_req_a32_d32_valid <= 1'b1;
            tmo_cnt                    <= '0;
            state                      <= REQ;
          end
        end
        REQ: begin
          if (reg_intf_resp_d32_ready) begin
            reg_intf_req_a32_d32_valid <= 1'b0;
            o_rsp_valid                <= 1'b1;
            o_rsp_rdata                <= reg_intf_req_a32_d32_write ? '0 : reg_intf_resp_d32_rdata;
            o_rsp_error                <= reg_intf_resp_d32_error;
            o_rsp_timeout              <= 1'b0;
            state                      <= RSP;
          end else if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            reg_intf_req_a32_d32_valid <= 1'b0;
            o_rsp_valid                <= 1'b1;
            o_rsp_rdata                <= '0;
            o_rsp_error                <= 1'b1;
            o_rsp_timeout              <= 1'b1;
            state                      <= RSP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        RSP: begin
          if (i_rsp_ready) begin
            o_rsp_valid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aplic_reg_initiator.sv
// Testbench for aplic_reg_initiator: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level queue model.
module tb_aplic_reg_initiator;

  localparam int DEPTH = 4;
  localparam int TMO   = 8;

  logic        i_clk = 1'b0;
  logic        ni_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        rsp_timeout;
  logic        busy;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        resp_ready;

  always #5 i_clk = ~i_clk;

  aplic_reg_initiator #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .i_clk(i_clk),
    .ni_rst(ni_rst),
    .i_cmd_valid(cmd_valid),
    .o_cmd_ready(cmd_ready),
    .i_cmd_addr(cmd_addr),
    .i_cmd_write(cmd_write),
    .i_cmd_wdata(cmd_wdata),
    .i_cmd_wstrb(cmd_wstrb),
    .o_rsp_valid(rsp_valid),
    .i_rsp_ready(rsp_ready),
    .o_rsp_rdata(rsp_rdata),
    .o_rsp_error(rsp_error),
    .o_rsp_timeout(rsp_timeout),
    .o_busy(busy),
    .reg_intf_req_a32_d32_addr(req_addr),
    .reg_intf_req_a32_d32_write(req_write),
    .reg_intf_req_a32_d32_wdata(req_wdata),
    .reg_intf_req_a32_d32_wstrb(req_wstrb),
    .reg_intf_req_a32_d32_valid(req_valid),
    .reg_intf_resp_d32_rdata(resp_rdata),
    .reg_intf_resp_d32_error(resp_error),
    .reg_intf_resp_d32_ready(resp_ready)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Responder: per transaction, ready after a chosen number of wait cycles.
  int          fixed_lat = -1;
  int          err_force = -1;
  bit          use_fixed_rdata = 1'b0;
  logic [31:0] fixed_rdata = 32'h0;
  bit          resp_active = 1'b0;
  int          resp_cnt, resp_lat;
  bit          resp_err_sel;

  initial begin
    resp_ready = 1'b0;
    resp_error = 1'b0;
    resp_rdata = 32'h0;
  end

  always @(posedge i_clk) begin
    #1;
    if (req_valid) begin
      if (!resp_active) begin
        resp_active  = 1'b1;
        resp_cnt     = 0;
        resp_lat     = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 10);
        resp_err_sel = (err_force >= 0) ? err_force[0] : ($urandom_range(0, 3) == 0);
      end else begin
        resp_cnt++;
      end
      resp_ready = (resp_cnt == resp_lat);
      resp_error = resp_err_sel;
      resp_rdata = use_fixed_rdata ? fixed_rdata : $urandom;
    end else begin
      resp_active = 1'b0;
      resp_ready  = ($urandom_range(0, 3) == 0);
      resp_error  = 1'($urandom_range(0, 1));
      resp_rdata  = $urandom;
    end
  end

  // Transaction-level model: pending command queue, the one live transaction and its response.
  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } cmd_s;

  cmd_s        m_q[$];
  cmd_s        m_act;
  cmd_s        m_new;
  bit          m_issuing, m_responding;
  int          m_shown;
  logic [31:0] m_rdata;
  bit          m_err, m_tmo;
  bit          model_live = 1'b0;
  bit          m_accept;
  int          m_size;

  always @(posedge i_clk) begin
    if (!ni_rst) begin
      m_q.delete();
      m_issuing    = 1'b0;
      m_responding = 1'b0;
      model_live   = 1'b1;
    end else if (model_live) begin
      m_size   = m_q.size();
      m_accept = cmd_valid && (m_size != DEPTH);
      m_new    = '{cmd_addr, cmd_write, cmd_wdata, cmd_wstrb};
      if (m_responding) begin
        if (rsp_ready) m_responding = 1'b0;
      end else if (m_issuing) begin
        if (resp_ready) begin
          m_issuing = 1'b0; m_responding = 1'b1;
          m_rdata = m_act.write ? 32'h0 : resp_rdata;
          m_err = resp_error; m_tmo = 1'b0;
        end else if (m_shown + 1 == TMO) begin
          m_issuing = 1'b0; m_responding = 1'b1;
          m_rdata = 32'h0; m_err = 1'b1; m_tmo = 1'b1;
        end else begin
          m_shown++;
        end
      end else if (m_size > 0) begin
        m_act     = m_q.pop_front();
        m_issuing = 1'b1;
        m_shown   = 0;
      end
      if (m_accept) m_q.push_back(m_new);
    end
  end

  always @(negedge i_clk) begin
    if (model_live) begin
      checkOutput("cmd_ready", 32'(cmd_ready), 32'(m_q.size() != DEPTH));
      checkOutput("busy", 32'(busy), 32'((m_q.size() != 0) || m_issuing || m_responding));
      checkOutput("req_valid", 32'(req_valid), 32'(m_issuing));
      checkOutput("rsp_valid", 32'(rsp_valid), 32'(m_responding));
      if (m_issuing) begin
        checkOutput("req_addr", req_addr, m_act.addr);
        checkOutput("req_write", 32'(req_write), 32'(m_act.write));
        checkOutput("req_wdata", req_wdata, m_act.write ? m_act.wdata : 32'h0);
        checkOutput("req_wstrb", 32'(req_wstrb), m_act.write ? 32'(m_act.wstrb) : 32'h0);
      end
      if (m_responding) begin
        checkOutput("rsp_rdata", rsp_rdata, m_rdata);
        checkOutput("rsp_error", 32'(rsp_error), 32'(m_err));
        checkOutput("rsp_timeout", 32'(rsp_timeout), 32'(m_tmo));
      end
    end
  end

  // Record the address of every request as it first appears, to check issue order.
  logic [31:0] issued_q[$];
  logic        prev_valid = 1'b0;

  always @(negedge i_clk) begin
    if (req_valid && !prev_valid) issued_q.push_back(req_addr);
    prev_valid = req_valid;
  end

  task automatic applyStimulus(input bit v, input logic [31:0] a, input bit w,
                               input logic [31:0] d, input logic [3:0] s, input bit rr);
    @(posedge i_clk);
    #1;
    ni_rst    = 1'b1;
    cmd_valid = v;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_wstrb = s;
    rsp_ready = rr;
  endtask

  task automatic idleCycle(input bit rr);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, rr);
  endtask

  task automatic waitIdle();
    bit done = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      idleCycle(1'b1);
      @(negedge i_clk);
      if (!busy) done = 1'b1;
    end
    checkOutput("drain_idle", 32'(busy), 32'h0);
  endtask

  // Counts request-valid cycles until the response appears, holding rsp_ready low.
  task automatic runTxn(input logic [31:0] exp_addr, output int vcycles);
    bit found = 1'b0;
    vcycles = 0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge i_clk);
      if (req_valid) begin
        vcycles++;
        checkOutput("txn_addr", req_addr, exp_addr);
      end
      if (rsp_valid) found = 1'b1;
      else idleCycle(1'b0);
    end
    checkOutput("txn_response_seen", 32'(found), 32'h1);
  endtask

  initial begin
    int vc;
    ni_rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
    cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 ni_rst = 1'b1;

    @(negedge i_clk);
    checkOutput("rst_req_valid", 32'(req_valid), 32'h0);
    checkOutput("rst_req_addr", req_addr, 32'h0);
    checkOutput("rst_req_wdata", req_wdata, 32'h0);
    checkOutput("rst_req_wstrb", 32'(req_wstrb), 32'h0);
    checkOutput("rst_req_write", 32'(req_write), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_flags", {30'h0, rsp_error, rsp_timeout}, 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // Write with immediate responder ready: valid one cycle at N+2, response at N+3.
    fixed_lat = 0; err_force = 0;
    applyStimulus(1'b1, 32'h0, 1'b1, 32'h104, 4'hF, 1'b1);
    idleCycle(1'b1);
    @(negedge i_clk);
    checkOutput("w1_n1_req_valid", 32'(req_valid), 32'h0);
    idleCycle(1'b1);
    @(negedge i_clk);
    checkOutput("w1_n2_req_valid", 32'(req_valid), 32'h1);
    checkOutput("w1_n2_wdata", req_wdata, 32'h104);
    checkOutput("w1_n2_wstrb", 32'(req_wstrb), 32'hF);
    idleCycle(1'b1);
    @(negedge i_clk);
    checkOutput("w1_n3_req_valid", 32'(req_valid), 32'h0);
    checkOutput("w1_n3_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("w1_n3_rdata", rsp_rdata, 32'h0);
    checkOutput("w1_n3_error", 32'(rsp_error), 32'h0);
    waitIdle();

    // Read with 5 wait cycles: six valid cycles, read data returned, strobes zeroed.
    fixed_lat = 5; use_fixed_rdata = 1'b1; fixed_rdata = 32'hDEAD_BEEF;
    applyStimulus(1'b1, 32'h3000, 1'b0, 32'h1234_5678, 4'hA, 1'b0);
    runTxn(32'h3000, vc);
    checkOutput("rd_valid_cycles", vc, 32'd6);
    checkOutput("rd_rdata", rsp_rdata, 32'hDEAD_BEEF);
    checkOutput("rd_error", 32'(rsp_error), 32'h0);
    waitIdle();

    // Responder never ready: aborted after exactly TMO valid cycles.
    fixed_lat = 1000;
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h0, 4'h0, 1'b0);
    runTxn(32'h40, vc);
    checkOutput("tmo_valid_cycles", vc, TMO);
    checkOutput("tmo_error", 32'(rsp_error), 32'h1);
    checkOutput("tmo_timeout", 32'(rsp_timeout), 32'h1);
    checkOutput("tmo_rdata", rsp_rdata, 32'h0);
    waitIdle();

    // Ready on the last allowed cycle beats the timeout.
    fixed_lat = TMO - 1;
    applyStimulus(1'b1, 32'h44, 1'b0, 32'h0, 4'h0, 1'b0);
    runTxn(32'h44, vc);
    checkOutput("late_valid_cycles", vc, TMO);
    checkOutput("late_timeout", 32'(rsp_timeout), 32'h0);
    checkOutput("late_error", 32'(rsp_error), 32'h0);
    checkOutput("late_rdata", rsp_rdata, 32'hDEAD_BEEF);
    waitIdle();
    use_fixed_rdata = 1'b0;

    // Five pushes with the response held: one in flight, four stored, FIFO full.
    fixed_lat = 0;
    issued_q.delete();
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h100 + 32'(4 * i), 1'b1, 32'(i), 4'hF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h200, 1'b1, 32'h0, 4'hF, 1'b0);
      @(negedge i_clk);
      checkOutput("full_cmd_ready", 32'(cmd_ready), 32'h0);
      checkOutput("full_busy", 32'(busy), 32'h1);
    end
    waitIdle();
    checkOutput("order_count", issued_q.size(), 32'd5);
    for (int i = 0; i < 5 && i < issued_q.size(); i++)
      checkOutput("order_addr", issued_q[i], 32'h100 + 32'(4 * i));

    // Responder error on a write; response held for 10 cycles blocks the next request.
    err_force = 1;
    applyStimulus(1'b1, 32'h80, 1'b1, 32'h55, 4'h3, 1'b0);
    runTxn(32'h80, vc);
    checkOutput("err_error", 32'(rsp_error), 32'h1);
    checkOutput("err_timeout", 32'(rsp_timeout), 32'h0);
    applyStimulus(1'b1, 32'h84, 1'b1, 32'h66, 4'hF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      idleCycle(1'b0);
      @(negedge i_clk);
      checkOutput("hold_req_valid", 32'(req_valid), 32'h0);
      checkOutput("hold_rsp_valid", 32'(rsp_valid), 32'h1);
      checkOutput("hold_rsp_error", 32'(rsp_error), 32'h1);
    end
    err_force = 0;
    waitIdle();

    // Reset while a request is outstanding and the FIFO is full.
    fixed_lat = 1000;
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h500 + 32'(4 * i), 1'b0, 32'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0);
    @(negedge i_clk);
    checkOutput("pre_rst_req_valid", 32'(req_valid), 32'h1);
    checkOutput("pre_rst_cmd_ready", 32'(cmd_ready), 32'h0);
    @(posedge i_clk);
    #1 ni_rst = 1'b0;
    @(posedge i_clk);
    #1 ni_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("post_rst_req_valid", 32'(req_valid), 32'h0);
    checkOutput("post_rst_busy", 32'(busy), 32'h0);
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);

    // Randomized traffic, responder latency/errors and occasional resets.
    fixed_lat = -1; err_force = -1;
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                    $urandom, 4'($urandom), $urandom_range(0, 9) < 7);
      if ($urandom_range(0, 399) == 0) ni_rst = 1'b0;
    end
    waitIdle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
